// File: rtl/butterfly_result_writer_if.sv
// Handshake bundle between the butterfly, the result writer and data memory.
// slave = writer view, master = driver/memory view.
interface butterfly_result_writer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              complx_control;
    logic [DATA_W-1:0] A_res;
    logic [DATA_W-1:0] B_res;
    logic [DATA_W-1:0] iA_res;
    logic [DATA_W-1:0] iB_res;
    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] idx_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  in_valid, complx_control, A_res, B_res, iA_res, iB_res,
               idx_a, idx_b, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport master (
        output in_valid, complx_control, A_res, B_res, iA_res, iB_res,
               idx_a, idx_b, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/butterfly_result_writer.sv
// Serialises one butterfly result set into memory writes (A, iA, B, iB).
// Define BFLY_SCALE_EN to halve every written word with rounding.
module butterfly_result_writer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int IMAG_OFFSET = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    butterfly_result_writer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, WR_AR, WR_AI, WR_BR, WR_BI} state_t;

    localparam logic [ADDR_W-1:0] IMAG_OFF = ADDR_W'(IMAG_OFFSET);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, ia_reg, b_reg, ib_reg;
    logic [ADDR_W-1:0] idx_a_reg, idx_b_reg;
    logic              cplx_reg;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              done_reg, done_next;
    logic              capture;

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x);
`ifdef BFLY_SCALE_EN
        logic [DATA_W:0] s;
        s = {x[DATA_W-1], x} + (DATA_W+1)'(1);
        return s[DATA_W:1];
`else
        return x;
`endif
    endfunction

    assign capture = bus.in_valid && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            ia_reg     <= '0;
            b_reg      <= '0;
            ib_reg     <= '0;
            idx_a_reg  <= '0;
            idx_b_reg  <= '0;
            cplx_reg   <= 1'b0;
            mem_we_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= mem_we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            done_reg   <= done_next;
            if (capture) begin
                a_reg     <= scale(bus.A_res);
                ia_reg    <= scale(bus.iA_res);
                b_reg     <= scale(bus.B_res);
                ib_reg    <= scale(bus.iB_res);
                idx_a_reg <= bus.idx_a;
                idx_b_reg <= bus.idx_b;
                cplx_reg  <= bus.complx_control;
            end
        end
    end

    // A write state advances only on the edge where the memory accepts it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = WR_AR;
            WR_AR:   if (bus.mem_ready) state_next = cplx_reg ? WR_AI : WR_BR;
            WR_AI:   if (bus.mem_ready) state_next = WR_BR;
            WR_BR:   if (bus.mem_ready) state_next = cplx_reg ? WR_BI : IDLE;
            WR_BI:   if (bus.mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address/data load only when entering a new write state, so they hold during stalls
    always_comb begin
        mem_we_next = (state_next != IDLE);
        done_next   = (state_reg != IDLE) && (state_next == IDLE);
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        if (capture) begin
            addr_next  = bus.idx_a;
            wdata_next = scale(bus.A_res);
        end else if (state_next != state_reg) begin
            case (state_next)
                WR_AI: begin
                    addr_next  = idx_a_reg + IMAG_OFF;
                    wdata_next = ia_reg;
                end
                WR_BR: begin
                    addr_next  = idx_b_reg;
                    wdata_next = b_reg;
                end
                WR_BI: begin
                    addr_next  = idx_b_reg + IMAG_OFF;
                    wdata_next = ib_reg;
                end
                default: begin
                    addr_next  = addr_reg;
                    wdata_next = wdata_reg;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_butterfly_result_writer.sv
// Directed self-checking bench for butterfly_result_writer.
module tb_butterfly_result_writer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    butterfly_result_writer_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    butterfly_result_writer #(.DATA_W(16), .ADDR_W(8), .IMAG_OFFSET(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected memory word for a raw result (rounded halving when scaling is built in)
    function automatic logic [15:0] exp_w(input logic [15:0] x);
`ifdef BFLY_SCALE_EN
        logic signed [16:0] s;
        s = $signed({x[15], x}) + 17'sd1;
        s = s >>> 1;
        return s[15:0];
`else
        return x;
`endif
    endfunction

    task automatic set_inputs(input logic cplx, input logic [7:0] ia, input logic [7:0] ib,
                              input logic [15:0] a, input logic [15:0] iav,
                              input logic [15:0] b, input logic [15:0] ibv);
        bus.complx_control = cplx;
        bus.idx_a  = ia;
        bus.idx_b  = ib;
        bus.A_res  = a;
        bus.iA_res = iav;
        bus.B_res  = b;
        bus.iB_res = ibv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total += 6;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
        if (bus.mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0000", bus.mem_wdata); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        $display("reset: in_ready=%b mem_we=%b busy=%b done=%b", bus.in_ready, bus.mem_we, bus.busy, bus.done);
    endtask

    task automatic test_complex();
        logic [7:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{8'h10, 8'h90, 8'h20, 8'hA0};
        ed = '{exp_w(16'h1111), exp_w(16'h2222), exp_w(16'h3333), exp_w(16'h4444)};
        set_inputs(1'b1, 8'h10, 8'h20, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
                bad++;
                $display("FAIL complex_wr%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea[i], ed[i]);
            end else $display("complex write %0d: addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata);
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL complex_done: got done=%b in_ready=%b we=%b want 1 1 0", bus.done, bus.in_ready, bus.mem_we);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL complex_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_real();
        logic [7:0]  ea [2];
        logic [15:0] ed [2];
        ea = '{8'h10, 8'h20};
        ed = '{exp_w(16'h1111), exp_w(16'h3333)};
        set_inputs(1'b0, 8'h10, 8'h20, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
                bad++;
                $display("FAIL real_wr%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea[i], ed[i]);
            end else $display("real write %0d: addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata);
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL real_done: got done=%b we=%b addr=%h want done=1 we=0", bus.done, bus.mem_we, bus.mem_addr);
        end
        tick();
        total++;
        if (bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL real_idle: got we=%b done=%b want 0 0", bus.mem_we, bus.done);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{8'h10, 8'h90, 8'h20, 8'hA0};
        ed = '{exp_w(16'h1111), exp_w(16'h2222), exp_w(16'h3333), exp_w(16'h4444)};
        set_inputs(1'b1, 8'h10, 8'h20, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.mem_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    total++;
                    if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[1] || bus.mem_wdata !== ed[1]) begin
                        bad++;
                        $display("FAIL bp_stall%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                                 s, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea[1], ed[1]);
                    end else $display("stall %0d: addr=%h data=%h held", s, bus.mem_addr, bus.mem_wdata);
                    tick();
                end
                bus.mem_ready = 1'b1;
            end
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
                bad++;
                $display("FAIL bp_wr%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea[i], ed[i]);
            end else $display("bp write %0d: addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata);
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL bp_done: got done=%b we=%b want 1 0", bus.done, bus.mem_we);
        end
        tick();
    endtask

    task automatic test_wrap_back_to_back();
        logic [7:0]  ea [8];
        logic [15:0] ed [8];
        ea = '{8'hF0, 8'h70, 8'h05, 8'h85, 8'h30, 8'hB0, 8'hFF, 8'h7F};
        ed = '{exp_w(16'hA001), exp_w(16'hA002), exp_w(16'hA003), exp_w(16'hA004),
               exp_w(16'h5001), exp_w(16'h5002), exp_w(16'h5003), exp_w(16'h5004)};
        set_inputs(1'b1, 8'hF0, 8'h05, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        bus.in_valid = 1'b1;
        tick();
        // second set is presented while busy; it must not disturb the first
        set_inputs(1'b1, 8'h30, 8'hFF, 16'h5001, 16'h5002, 16'h5003, 16'h5004);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                total++;
                if (bus.done !== 1'b1 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_done: got done=%b in_ready=%b we=%b want 1 1 0", bus.done, bus.in_ready, bus.mem_we);
                end
                tick();
                bus.in_valid = 1'b0;
            end
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
                bad++;
                $display("FAIL b2b_wr%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea[i], ed[i]);
            end else $display("b2b write %0d: addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata);
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done2: got done=%b we=%b want 1 0", bus.done, bus.mem_we);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_inputs(1'b1, 8'h10, 8'h20, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h20) begin
            bad++;
            $display("FAIL rst_mid_in_br: got we=%b addr=%h want we=1 addr=20", bus.mem_we, bus.mem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort: got we=%b in_ready=%b done=%b want 0 1 0", bus.mem_we, bus.in_ready, bus.done);
        end else $display("reset mid-set: aborted, in_ready=%b", bus.in_ready);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_quiet%0d: got we=%b done=%b want 0 0", i, bus.mem_we, bus.done);
            end
        end
    endtask

`ifdef BFLY_SCALE_EN
    task automatic test_scale();
        logic [7:0]  ea [4];
        logic [15:0] ed [4];
        ea = '{8'h01, 8'h81, 8'h02, 8'h82};
        ed = '{16'h4000, 16'hC000, 16'h0002, 16'hFFFF};
        set_inputs(1'b1, 8'h01, 8'h02, 16'h7FFF, 16'h8000, 16'h0003, 16'hFFFD);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
                bad++;
                $display("FAIL scale_wr%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, bus.mem_addr, bus.mem_wdata, ea[i], ed[i]);
            end else $display("scaled write %0d: addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata);
            tick();
        end
        tick();
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        set_inputs(1'b0, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_complex();
        test_real();
        test_backpressure();
        test_wrap_back_to_back();
        test_reset_mid();
`ifdef BFLY_SCALE_EN
        test_scale();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/butterfly_result_writer.md
Name: butterfly_result_writer

Overview:
- Output-side counterpart of the FFT butterfly operand selector: takes one butterfly's results (A, B and their imaginary parts) and writes them back to data memory as a serial stream of DATA_W words.
- Uses a valid/ready handshake toward the butterfly and a write-request/ready handshake toward memory.
- Real mode writes only the real parts; complex mode writes real and imaginary parts.

Parameters:
- DATA_W, 16, width of each result word and of the memory data bus.
- ADDR_W, 8, memory address width; all address arithmetic is modulo 2^ADDR_W.
- IMAG_OFFSET, 128, address distance from a real word to its imaginary word.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  butterfly result set available.
- in_ready  output  1  writer can accept a result set.
- complx_control  input  1  0 = real mode, 1 = complex mode; sampled at capture.
- A_res, B_res, iA_res, iB_res  input  DATA_W each  butterfly results, two's complement.
- idx_a, idx_b  input  ADDR_W each  destination indices for the A and B results.
- mem_we  output  1  write request.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse after the last write of a set is accepted.

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; FSM goes to IDLE and all captured registers clear.
- Reset mid-operation aborts the set; no further writes are issued.

State machine (IDLE, WR_AR, WR_AI, WR_BR, WR_BI):
- in_ready = (state==IDLE), combinationally.
- Capture:
  - Occurs when in_valid && in_ready at a clock edge.
  - Registers all four results, both indices and the mode.
  - Next state is WR_AR.
- Write states:
  - mem_we=1; mem_addr and mem_wdata are registered and stay stable until mem_ready=1.
  - A write completes on the edge where mem_we && mem_ready.
  - Each state stalls indefinitely while mem_ready=0.
- Addresses and data per state:
  - WR_AR: addr = idx_a, data = A.
  - WR_AI: addr = idx_a + IMAG_OFFSET, data = iA.
  - WR_BR: addr = idx_b, data = B.
  - WR_BI: addr = idx_b + IMAG_OFFSET, data = iB.
  - All sums wrap modulo 2^ADDR_W.
- Transitions:
  - Complex mode: WR_AR -> WR_AI -> WR_BR -> WR_BI -> IDLE.
  - Real mode: WR_AR -> WR_BR -> IDLE; imaginary results are ignored.
- done: registered, high for exactly the one cycle after the final accepted write (the first cycle back in IDLE).
- Latency with mem_ready held at 1 and capture at edge N:
  - First mem_we is high in cycle N+1.
  - Complex mode: 4 write cycles; done and in_ready are high in cycle N+5.
  - Real mode: 2 write cycles; done is high in cycle N+3.
- Back-to-back: a new set may be captured in the same cycle that done=1.
- Inputs are ignored while busy; the mode and results cannot change mid-set.
- idx_a == idx_b is legal: the B writes overwrite the A writes, in order.
- mem_we is never high in IDLE, and no write is ever issued twice.

Optional Feature:
- Macro: BFLY_SCALE_EN.
- Defined:
  - Every written word is scaled by 1/2 with rounding: (x + 1) >>> 1, computed in DATA_W+1 bits and truncated to DATA_W.
  - This never overflows; it gives per-stage FFT scaling.
  - Scaling is applied at capture, so there is no added latency.
- Undefined: words are written unmodified.

Test Plan:
- Complex set, mem_ready=1, idx_a=0x10, idx_b=0x20, A/iA/B/iB = 0x1111/0x2222/0x3333/0x4444 -> writes (0x10,0x1111), (0x90,0x2222), (0x20,0x3333), (0xA0,0x4444) on consecutive cycles; done 1 cycle later.
- Real mode with the same inputs -> exactly two writes, (0x10,0x1111) then (0x20,0x3333); done at N+3; no 0x90/0xA0 writes.
- Backpressure: mem_ready=0 for 3 cycles during WR_AI -> addr 0x90 and data 0x2222 held stable; the write completes once mem_ready rises; total latency +3.
- Wrap: idx_a=0xF0 complex -> imaginary address 0x70; back-to-back sets with in_valid held high -> the second set is captured on the done cycle with no idle gap.
- rst asserted in WR_BR -> mem_we=0 and in_ready=1 next cycle; B is never written; done stays 0.
- BFLY_SCALE_EN: A=0x7FFF -> 0x4000; A=0x8000 -> 0xC000; A=0x0003 -> 0x0002; A=0xFFFD -> 0xFFFF.
